vio_route_ctrl: RTL and testbench

Per-region route configuration controller for the vFPGA stream switch. Holds one 14-bit tdest route per region and drives it onto the switch's `route_in` bus. New routes arrive over a valid/ready config port and are committed only at packet boundaries of that region's user-logic (dtu) sink stream, so tdest never changes mid-packet or under a stalled beat. Sits between the control-register path and the switch.

---
 rtl/lynxTypes.sv | 12 +
 rtl/vio_route_slot.sv | 76 +++++++
 rtl/vio_route_ctrl.sv | 84 ++++++++
 tb/tb_vio_route_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lynxTypes.sv
// rtl/lynxTypes.sv - shared vFPGA types and constants
// Purpose: region count, route width and route type used by the stream-switch
//          route control logic.
// Ports:   none (package).
package lynxTypes;

   localparam int N_REGIONS  = 4;
   localparam int ROUTE_BITS = 14;

   typedef logic [ROUTE_BITS-1:0] route_t;

endpackage

// File: rtl/vio_route_slot.sv
// rtl/vio_route_slot.sv - one region's route register with packet-boundary commit
// Purpose: tracks whether the region's dtu sink stream is inside a packet,
//          holds a shadow route and commits it only when tdest can safely change.
// Ports:
//   aclk, areset           clock, asynchronous active-high reset
//   wr_en, wr_route        accepted config write for this region and its route
//   flush                  drop the shadow route (no commit this cycle)
//   tvalid, tready, tlast  monitored dtu sink handshake
//   route                  committed route (registered)
//   pending                shadow route waiting to commit (registered)
//   upd_done               one-cycle pulse on commit (registered)
module vio_route_slot
   import lynxTypes::*;
#(
   parameter route_t RESET_ROUTE = '0
) (
   input  logic   aclk,
   input  logic   areset,
   input  logic   wr_en,
   input  route_t wr_route,
   input  logic   flush,
   input  logic   tvalid,
   input  logic   tready,
   input  logic   tlast,
   output route_t route,
   output logic   pending,
   output logic   upd_done
);

   logic   in_pkt;
   route_t shadow;
   logic   hs;
   logic   safe;

   assign hs = tvalid & tready;

   // Idle with nothing presented, or the final beat of a packet transferring now.
   // A presented-but-stalled first beat is deliberately not safe: its tdest is
   // already on the wire and must not move under it.
   assign safe = (!in_pkt & !tvalid) | (hs & tlast);

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         in_pkt   <= 1'b0;
         shadow   <= RESET_ROUTE;
         route    <= RESET_ROUTE;
         pending  <= 1'b0;
         upd_done <= 1'b0;
      end else begin
         upd_done <= 1'b0;

         if (hs) begin
            in_pkt <= !tlast;
         end

         // wr_en is never asserted while pending is set, so the write and
         // deferred-commit branches never compete.
         if (flush) begin
            pending <= 1'b0;
         end else if (wr_en) begin
            if (safe) begin
               route    <= wr_route;
               upd_done <= 1'b1;
            end else begin
               shadow  <= wr_route;
               pending <= 1'b1;
            end
         end else if (pending && safe) begin
            route    <= shadow;
            pending  <= 1'b0;
            upd_done <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/vio_route_ctrl.sv
// rtl/vio_route_ctrl.sv - per-region route controller for the vFPGA stream switch
// Purpose: decodes config writes to per-region route slots, applies one
//          outstanding write per region and drives committed routes to the switch.
// Ports:
//   aclk, areset                    clock, asynchronous active-high reset
//   cfg_valid, cfg_ready            config write handshake (cfg_ready combinational)
//   cfg_region, cfg_route           target region and new route
//   cfg_flush                       drop all pending routes
//   cfg_err                         pulse after an accepted write to a bad region
//   mon_tvalid/tready/tlast         per-region dtu sink stream monitor
//   route_out                       committed routes (switch route_in)
//   route_pending, upd_done         per-region pending flag and commit pulse
module vio_route_ctrl
   import lynxTypes::*;
#(
   parameter int     N_ID        = N_REGIONS,
   parameter route_t RESET_ROUTE = 14'h0000
) (
   input  logic                             aclk,
   input  logic                             areset,
   input  logic                             cfg_valid,
   output logic                             cfg_ready,
   input  logic [7:0]                       cfg_region,
   input  logic [ROUTE_BITS-1:0]            cfg_route,
   input  logic                             cfg_flush,
   output logic                             cfg_err,
   input  logic [N_ID-1:0]                  mon_tvalid,
   input  logic [N_ID-1:0]                  mon_tready,
   input  logic [N_ID-1:0]                  mon_tlast,
   output logic [N_ID-1:0][ROUTE_BITS-1:0]  route_out,
   output logic [N_ID-1:0]                  route_pending,
   output logic [N_ID-1:0]                  upd_done
);

   logic            region_ok;
   logic            pend_sel;
   logic            accept;
   logic [N_ID-1:0] wr_en;

   assign region_ok = (32'(cfg_region) < N_ID);

   // Pending bit of the addressed region; out-of-range regions read as free so
   // that bad writes are accepted and reported rather than stalling the port.
   always_comb begin
      pend_sel = 1'b0;
      wr_en    = '0;
      for (int i = 0; i < N_ID; i++) begin
         if (32'(cfg_region) == i) begin
            pend_sel = route_pending[i];
            wr_en[i] = accept;
         end
      end
   end

   assign cfg_ready = !cfg_flush & (!region_ok | !pend_sel);
   assign accept    = cfg_valid & cfg_ready;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= accept & !region_ok;
      end
   end

   for (genvar g = 0; g < N_ID; g++) begin : g_slot
      vio_route_slot #(
         .RESET_ROUTE (RESET_ROUTE)
      ) u_slot (
         .aclk     (aclk),
         .areset   (areset),
         .wr_en    (wr_en[g]),
         .wr_route (cfg_route),
         .flush    (cfg_flush),
         .tvalid   (mon_tvalid[g]),
         .tready   (mon_tready[g]),
         .tlast    (mon_tlast[g]),
         .route    (route_out[g]),
         .pending  (route_pending[g]),
         .upd_done (upd_done[g])
      );
   end

endmodule

// File: tb/tb_vio_route_ctrl.sv
// tb/tb_vio_route_ctrl.sv - self-checking bench for vio_route_ctrl
module tb_vio_route_ctrl;

   localparam int NR = 4;

   logic                 aclk;
   logic                 areset;
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [7:0]           cfg_region;
   logic [13:0]          cfg_route;
   logic                 cfg_flush;
   logic                 cfg_err;
   logic [NR-1:0]        mon_tvalid;
   logic [NR-1:0]        mon_tready;
   logic [NR-1:0]        mon_tlast;
   logic [NR-1:0][13:0]  route_out;
   logic [NR-1:0]        route_pending;
   logic [NR-1:0]        upd_done;

   int n_cmp = 0;
   int n_bad = 0;

   logic [13:0] exp_q [NR][$];
   logic [13:0] mdl   [NR];
   logic [13:0] sb_e;

   vio_route_ctrl #(
      .N_ID        (NR),
      .RESET_ROUTE (14'h0000)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_region    (cfg_region),
      .cfg_route     (cfg_route),
      .cfg_flush     (cfg_flush),
      .cfg_err       (cfg_err),
      .mon_tvalid    (mon_tvalid),
      .mon_tready    (mon_tready),
      .mon_tlast     (mon_tlast),
      .route_out     (route_out),
      .route_pending (route_pending),
      .upd_done      (upd_done)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp_v);
      end
   endtask

   task automatic step;
      @(posedge aclk);
      #1;
   endtask

   task automatic cfg_write(input int r, input logic [13:0] v, input logic exp_rdy);
      cfg_valid  = 1'b1;
      cfg_region = 8'(r);
      cfg_route  = v;
      #1;
      chk($sformatf("cfg_ready_r%0d", r), 32'(cfg_ready), 32'(exp_rdy));
      if (exp_rdy && r < NR) exp_q[r].push_back(v);
      step;
      cfg_valid = 1'b0;
   endtask

   // Scoreboard: every commit pulse must match the oldest expected route.
   always @(negedge aclk) begin
      if (!areset) begin
         for (int i = 0; i < NR; i++) begin
            if (upd_done[i]) begin
               if (exp_q[i].size() == 0) begin
                  chk($sformatf("sb_unexpected_upd_r%0d", i), 32'd1, 32'd0);
               end else begin
                  sb_e = exp_q[i].pop_front();
                  chk($sformatf("sb_route_r%0d", i), 32'(route_out[i]), 32'(sb_e));
                  mdl[i] = sb_e;
               end
            end
         end
      end
   end

   initial begin
      areset     = 1'b1;
      cfg_valid  = 1'b0;
      cfg_region = 8'd0;
      cfg_route  = 14'h0;
      cfg_flush  = 1'b0;
      mon_tvalid = '0;
      mon_tready = '0;
      mon_tlast  = '0;
      for (int i = 0; i < NR; i++) mdl[i] = 14'h0;

      // reset state
      step;
      step;
      for (int i = 0; i < NR; i++) chk($sformatf("rst_route_r%0d", i), 32'(route_out[i]), 32'h0);
      chk("rst_pending", 32'(route_pending), 32'h0);
      chk("rst_upd_done", 32'(upd_done), 32'h0);
      chk("rst_cfg_err", 32'(cfg_err), 32'h0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);
      areset = 1'b0;
      step;

      // idle write: bypass commit
      cfg_write(1, 14'h0123, 1'b1);
      chk("idle_route_r1", 32'(route_out[1]), 32'h0123);
      chk("idle_upd_r1", 32'(upd_done[1]), 32'h1);
      chk("idle_pend_r1", 32'(route_pending[1]), 32'h0);
      step;
      chk("idle_upd_off", 32'(upd_done), 32'h0);

      // mid-packet write on region 0
      mon_tvalid[0] = 1'b1; mon_tready[0] = 1'b1; mon_tlast[0] = 1'b0;
      step;
      step;
      mon_tvalid[0] = 1'b0;
      cfg_write(0, 14'h0A5C, 1'b1);
      chk("mid_pend_r0", 32'(route_pending[0]), 32'h1);
      chk("mid_hold_r0", 32'(route_out[0]), 32'h0);
      mon_tvalid[0] = 1'b1;
      step;
      chk("mid_hold3_r0", 32'(route_out[0]), 32'h0);
      mon_tlast[0] = 1'b1;
      step;
      chk("mid_commit_r0", 32'(route_out[0]), 32'h0A5C);
      chk("mid_pend_clr_r0", 32'(route_pending[0]), 32'h0);
      mon_tvalid[0] = 1'b0; mon_tlast[0] = 1'b0;

      // stalled first beat on region 2
      mon_tvalid[2] = 1'b1; mon_tready[2] = 1'b0; mon_tlast[2] = 1'b1;
      cfg_write(2, 14'h0011, 1'b1);
      chk("stall_pend_r2", 32'(route_pending[2]), 32'h1);
      chk("stall_hold_r2_0", 32'(route_out[2]), 32'h0);
      for (int k = 1; k < 5; k++) begin
         step;
         chk($sformatf("stall_hold_r2_%0d", k), 32'(route_out[2]), 32'h0);
      end
      mon_tready[2] = 1'b1;
      step;
      chk("stall_commit_r2", 32'(route_out[2]), 32'h0011);
      chk("stall_pend_clr_r2", 32'(route_pending[2]), 32'h0);
      mon_tvalid[2] = 1'b0; mon_tready[2] = 1'b0; mon_tlast[2] = 1'b0;

      // config back-pressure
      mon_tvalid[0] = 1'b1; mon_tready[0] = 1'b1; mon_tlast[0] = 1'b0;
      step;
      mon_tvalid[0] = 1'b0;
      cfg_write(0, 14'h0BEE, 1'b1);
      chk("bp_pend_r0", 32'(route_pending[0]), 32'h1);
      cfg_write(0, 14'h1111, 1'b0);
      chk("bp_hold_r0", 32'(route_out[0]), 32'h0A5C);
      cfg_write(3, 14'h3C3C, 1'b1);
      chk("bp_commit_r3", 32'(route_out[3]), 32'h3C3C);
      mon_tvalid[0] = 1'b1; mon_tlast[0] = 1'b1;
      step;
      chk("bp_commit_r0", 32'(route_out[0]), 32'h0BEE);
      mon_tvalid[0] = 1'b0; mon_tlast[0] = 1'b0;
      step;

      // out-of-range region
      cfg_write(NR, 14'h3FFF, 1'b1);
      chk("err_pulse", 32'(cfg_err), 32'h1);
      for (int i = 0; i < NR; i++) chk($sformatf("err_route_r%0d", i), 32'(route_out[i]), 32'(mdl[i]));
      step;
      chk("err_clear", 32'(cfg_err), 32'h0);

      // flush a pending route on region 1
      mon_tvalid[1] = 1'b1; mon_tready[1] = 1'b1; mon_tlast[1] = 1'b0;
      step;
      mon_tvalid[1] = 1'b0;
      cfg_write(1, 14'h2222, 1'b1);
      chk("fl_pend_r1", 32'(route_pending[1]), 32'h1);
      cfg_flush = 1'b1;
      #1;
      chk("fl_ready", 32'(cfg_ready), 32'h0);
      step;
      cfg_flush = 1'b0;
      exp_q[1].delete();
      chk("fl_pend_clr_r1", 32'(route_pending[1]), 32'h0);
      chk("fl_route_r1", 32'(route_out[1]), 32'h0123);
      mon_tvalid[1] = 1'b1; mon_tlast[1] = 1'b1;
      step;
      mon_tvalid[1] = 1'b0; mon_tlast[1] = 1'b0;
      step;
      chk("fl_route_after_r1", 32'(route_out[1]), 32'h0123);

      // reset mid-packet
      mon_tvalid[0] = 1'b1; mon_tready[0] = 1'b1; mon_tlast[0] = 1'b0;
      step;
      cfg_write(0, 14'h0777, 1'b1);
      chk("rm_pend_r0", 32'(route_pending[0]), 32'h1);
      areset = 1'b1;
      #1;
      for (int i = 0; i < NR; i++) chk($sformatf("rm_route_r%0d", i), 32'(route_out[i]), 32'h0);
      chk("rm_pending", 32'(route_pending), 32'h0);
      for (int i = 0; i < NR; i++) begin
         exp_q[i].delete();
         mdl[i] = 14'h0;
      end
      mon_tvalid = '0; mon_tready = '0; mon_tlast = '0;
      step;
      areset = 1'b0;
      step;
      cfg_write(0, 14'h0042, 1'b1);
      chk("rm_commit_r0", 32'(route_out[0]), 32'h0042);
      chk("rm_upd_r0", 32'(upd_done[0]), 32'h1);
      step;
      step;

      for (int i = 0; i < NR; i++) chk($sformatf("sb_left_r%0d", i), 32'(exp_q[i].size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
